// File: rtl/nibble_rx_pkg.sv
// -----------------------------------------------------------------------------
// nibble_rx_pkg
// Shared definitions for the nibble_rx serial receiver:
//   - state_e     : receiver FSM states (IDLE, START, DATA, STOP)
//   - *_DEF       : default frame geometry
//   - HALF_BIT    : start-bit midpoint offset for the default bit period
//   - half_bit()  : midpoint offset for an arbitrary bit period
// -----------------------------------------------------------------------------
package nibble_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam int CLKS_PER_BIT_DEF = 4;
   localparam int DATA_W_DEF       = 4;
   localparam int HALF_BIT         = CLKS_PER_BIT_DEF / 2;

   // Clock cycles from the detected start edge to the start-bit midpoint.
   function automatic int half_bit(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/nibble_rx_if.sv
// -----------------------------------------------------------------------------
// nibble_rx_if
// Bundles the serial line and the parallel word/strobe outputs of nibble_rx.
//   rx        : serial line, idle high (driven by the line side)
//   data      : last correctly received word
//   load      : one-cycle strobe, data is new in the same cycle
//   frame_err : one-cycle strobe, stop bit was sampled low
//   busy      : high while a frame is being received
// Modports:
//   master : line driver / downstream consumer side
//   slave  : the receiver itself
// -----------------------------------------------------------------------------
interface nibble_rx_if #(
   parameter int DATA_W = 4
) ();

   logic              rx;
   logic [DATA_W-1:0] data;
   logic              load;
   logic              frame_err;
   logic              busy;

   modport master (
      output rx,
      input  data,
      input  load,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  rx,
      output data,
      output load,
      output frame_err,
      output busy
   );

endinterface

// File: rtl/nibble_rx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   rst   : asynchronous active-high reset, both flops load RST_VAL
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clk cycles behind d_i
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/nibble_rx.sv
// -----------------------------------------------------------------------------
// nibble_rx
// UART-style serial receiver: start bit (0), DATA_W data bits LSB first,
// stop bit (1). Produces a parallel word with a one-cycle load strobe, or a
// one-cycle frame_err strobe when the stop bit is sampled low.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : nibble_rx_if.slave (rx in; data, load, frame_err, busy out)
// All outputs are registered. Sampling decisions use only the synchronized
// line; every sample lands on the middle of a bit cell.
// -----------------------------------------------------------------------------
module nibble_rx
   import nibble_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_W       = DATA_W_DEF
) (
   input logic        clk,
   input logic        rst,
   nibble_rx_if.slave bus
);

   localparam int CYC_W    = $clog2(CLKS_PER_BIT);
   localparam int BIT_W    = $clog2(DATA_W + 1);
   localparam int HALF_CYC = half_bit(CLKS_PER_BIT);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_START = START;
   localparam logic [1:0] ST_DATA  = DATA;
   localparam logic [1:0] ST_STOP  = STOP;

   // The START counter begins the cycle after the edge is seen, so the
   // midpoint is reached when it shows HALF_CYC-1.
   localparam logic [CYC_W-1:0] CYC_HALF_LAST = CYC_W'(HALF_CYC - 1);
   localparam logic [CYC_W-1:0] CYC_BIT_LAST  = CYC_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_W - 1);

   logic              rx_s;

   logic [1:0]        state_q, state_d;
   logic [CYC_W-1:0]  cyc_q,   cyc_d;
   logic [BIT_W-1:0]  bit_q,   bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              load_q,  load_d;
   logic              ferr_q,  ferr_d;
   logic              busy_q,  busy_d;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.rx),
      .q_o (rx_s)
   );

   // Next-state logic for the receive FSM, counters, shifter and strobes.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      load_d  = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cyc_d = {CYC_W{1'b0}};
            if (!rx_s) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_START: begin
            if (cyc_q == CYC_HALF_LAST) begin
               cyc_d = {CYC_W{1'b0}};
               bit_d = {BIT_W{1'b0}};
               // A line that is high again at the midpoint was only a glitch.
               if (!rx_s) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end

         ST_DATA: begin
            if (cyc_q == CYC_BIT_LAST) begin
               cyc_d   = {CYC_W{1'b0}};
               // LSB arrives first, so new bits enter at the top and move down.
               shift_d = {rx_s, shift_q[DATA_W-1:1]};
               if (bit_q == BIT_LAST) begin
                  bit_d   = {BIT_W{1'b0}};
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end

         ST_STOP: begin
            if (cyc_q == CYC_BIT_LAST) begin
               cyc_d   = {CYC_W{1'b0}};
               state_d = ST_IDLE;
               if (rx_s) begin
                  data_d = shift_q;
                  load_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            cyc_d   = {CYC_W{1'b0}};
            bit_d   = {BIT_W{1'b0}};
         end
      endcase

      // busy follows the state being entered so it is registered with it.
      busy_d = (state_d != ST_IDLE);
   end

   // State, counter, shifter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cyc_q   <= {CYC_W{1'b0}};
         bit_q   <= {BIT_W{1'b0}};
         shift_q <= {DATA_W{1'b0}};
         data_q  <= {DATA_W{1'b0}};
         load_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         load_q  <= load_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.load      = load_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = busy_q;

endmodule
